// File: rtl/acc_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// acc_ctrl_fsm_if
// Bundles the control unit's connection to the accumulator datapath.
//   Opcode, AccZero, MemReady        : datapath/memory -> controller
//   SrcA/SrcB/ALUOP/MemAddrSrc       : datapath source and operation selects
//   MemReq/MemWrite                  : memory handshake (held until MemReady)
//   IRWrite..SPWrite                 : register load strobes
//   Halted/IllegalOp/BusError/State  : status and debug
// Modport master is the controller side, slave is the datapath side.
// ---------------------------------------------------------------------------
interface acc_ctrl_fsm_if;
    logic [3:0] Opcode;
    logic       AccZero;
    logic       MemReady;
    logic [2:0] SrcA;
    logic [3:0] SrcB;
    logic [2:0] ALUOP;
    logic [1:0] MemAddrSrc;
    logic       MemReq;
    logic       MemWrite;
    logic       IRWrite;
    logic       MDRWrite;
    logic       PCWrite;
    logic       ACCWrite;
    logic       SPWrite;
    logic       Halted;
    logic       IllegalOp;
    logic       BusError;
    logic [3:0] State;

    modport master (
        input  Opcode, AccZero, MemReady,
        output SrcA, SrcB, ALUOP, MemAddrSrc, MemReq, MemWrite,
               IRWrite, MDRWrite, PCWrite, ACCWrite, SPWrite,
               Halted, IllegalOp, BusError, State
    );

    modport slave (
        output Opcode, AccZero, MemReady,
        input  SrcA, SrcB, ALUOP, MemAddrSrc, MemReq, MemWrite,
               IRWrite, MDRWrite, PCWrite, ACCWrite, SPWrite,
               Halted, IllegalOp, BusError, State
    );
endinterface

// File: rtl/acc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// acc_ctrl_fsm
// Multicycle control unit for the 16-bit accumulator datapath. Steps through
// fetch / decode / execute / writeback and drives the ALU selects, memory
// handshake and register load strobes.
// Ports:
//   CLK  - rising-edge clock
//   RST  - asynchronous active-high reset
//   bus  - acc_ctrl_fsm_if.master (opcode, flags, selects, strobes, status)
// Parameters:
//   MAX_WAIT - memory wait cycles tolerated before a bus error (1..255)
//   PC_INC   - byte increment the datapath applies for SrcB=4
// ---------------------------------------------------------------------------
module acc_ctrl_fsm #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned PC_INC   = 2
) (
    input  logic           CLK,
    input  logic           RST,
    acc_ctrl_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMRD  = 4'd3,
        S_ALU    = 4'd4,
        S_MEMWR  = 4'd5,
        S_BRANCH = 4'd6,
        S_JUMP   = 4'd7,
        S_SPDEC  = 4'd8,
        S_PUSHWR = 4'd9,
        S_POPRD  = 4'd10,
        S_POPINC = 4'd11,
        S_POPWB  = 4'd12,
        S_HALT   = 4'd13,
        S_ERROR  = 4'd14
    } state_t;

    // Select encodings
    localparam logic [2:0] SRCA_PC  = 3'd0;
    localparam logic [2:0] SRCA_ACC = 3'd1;
    localparam logic [2:0] SRCA_SP  = 3'd2;
    localparam logic [3:0] SRCB_MDR = 4'd0;
    localparam logic [3:0] SRCB_SE  = 4'd1;
    localparam logic [3:0] SRCB_ZE  = 4'd2;
    localparam logic [3:0] SRCB_SL1 = 4'd3;
    localparam logic [3:0] SRCB_C0  = 4'd5;
    // A zero increment is the same operand as the constant-zero source.
    localparam logic [3:0] SRCB_INC = (PC_INC != 0) ? 4'd4 : SRCB_C0;
    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_PASSB = 3'd4;
    localparam logic [1:0] MA_PC    = 2'd0;
    localparam logic [1:0] MA_ZE    = 2'd1;
    localparam logic [1:0] MA_SP    = 2'd2;

    localparam logic [8:0] WAIT_LIMIT = 9'(MAX_WAIT);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [3:0] opcode_q, opcode_d;
    logic       illegal_q, illegal_d;
    logic       bus_err_q, bus_err_d;
    logic       mem_state;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_INIT;
            wait_q    <= '0;
            opcode_q  <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                       (state_q == S_MEMWR) || (state_q == S_PUSHWR) ||
                       (state_q == S_POPRD);

    // -----------------------------------------------------------------------
    // Next state, opcode latch, wait counter, sticky flags
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        opcode_d  = opcode_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;

        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  if (bus.MemReady) state_d = S_DECODE;
            S_DECODE: begin
                // Later states only look at the latched copy, so the
                // Opcode input may change freely once decode is done.
                opcode_d = bus.Opcode;
                case (bus.Opcode)
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h5: state_d = S_MEMRD;
                    4'h4: state_d = S_ALU;
                    4'h6: state_d = S_MEMWR;
                    4'h7, 4'h8: state_d = S_BRANCH;
                    4'h9: state_d = S_JUMP;
                    4'hA: state_d = S_SPDEC;
                    4'hB: state_d = S_POPRD;
                    4'hF: state_d = S_HALT;
                    default: begin
                        state_d   = S_ERROR;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMRD:  if (bus.MemReady) state_d = S_ALU;
            S_ALU:    state_d = S_FETCH;
            S_MEMWR:  if (bus.MemReady) state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_SPDEC:  state_d = S_PUSHWR;
            S_PUSHWR: if (bus.MemReady) state_d = S_FETCH;
            S_POPRD:  if (bus.MemReady) state_d = S_POPINC;
            S_POPINC: state_d = S_POPWB;
            S_POPWB:  state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_ERROR;
        endcase

        // Counts stalled memory cycles. Any cycle that is not a stall
        // clears it, so every memory state starts from zero. A MemReady on
        // the limit cycle takes the normal path above.
        if (mem_state && !bus.MemReady) begin
            if (({1'b0, wait_q} + 9'd1) == WAIT_LIMIT) begin
                state_d   = S_ERROR;
                bus_err_d = 1'b1;
                wait_d    = '0;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end else begin
            wait_d = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Moore output decode; load strobes of memory states wait for MemReady
    // -----------------------------------------------------------------------
    always_comb begin
        bus.SrcA       = SRCA_PC;
        bus.SrcB       = SRCB_MDR;
        bus.ALUOP      = OP_ADD;
        bus.MemAddrSrc = MA_PC;
        bus.MemReq     = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.MDRWrite   = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.ACCWrite   = 1'b0;
        bus.SPWrite    = 1'b0;
        bus.Halted     = 1'b0;

        case (state_q)
            S_FETCH: begin
                bus.MemReq     = 1'b1;
                bus.MemAddrSrc = MA_PC;
                bus.SrcA       = SRCA_PC;
                bus.SrcB       = SRCB_INC;
                bus.ALUOP      = OP_ADD;
                bus.IRWrite    = bus.MemReady;
                bus.PCWrite    = bus.MemReady;
            end
            S_MEMRD: begin
                bus.MemReq     = 1'b1;
                bus.MemAddrSrc = MA_ZE;
                bus.MDRWrite   = bus.MemReady;
            end
            S_ALU: begin
                bus.SrcA     = SRCA_ACC;
                bus.ACCWrite = 1'b1;
                bus.SrcB     = (opcode_q == 4'h4) ? SRCB_SE : SRCB_MDR;
                case (opcode_q)
                    4'h1:    bus.ALUOP = OP_SUB;
                    4'h2:    bus.ALUOP = OP_AND;
                    4'h3:    bus.ALUOP = OP_OR;
                    4'h5:    bus.ALUOP = OP_PASSB;
                    default: bus.ALUOP = OP_ADD;
                endcase
            end
            S_MEMWR: begin
                bus.MemReq     = 1'b1;
                bus.MemWrite   = 1'b1;
                bus.MemAddrSrc = MA_ZE;
            end
            S_BRANCH: begin
                bus.SrcA    = SRCA_PC;
                bus.SrcB    = SRCB_SL1;
                bus.ALUOP   = OP_ADD;
                bus.PCWrite = (opcode_q == 4'h7) ? bus.AccZero : !bus.AccZero;
            end
            S_JUMP: begin
                bus.SrcB    = SRCB_ZE;
                bus.ALUOP   = OP_PASSB;
                bus.PCWrite = 1'b1;
            end
            S_SPDEC: begin
                bus.SrcA    = SRCA_SP;
                bus.SrcB    = SRCB_INC;
                bus.ALUOP   = OP_SUB;
                bus.SPWrite = 1'b1;
            end
            S_PUSHWR: begin
                bus.MemReq     = 1'b1;
                bus.MemWrite   = 1'b1;
                bus.MemAddrSrc = MA_SP;
            end
            S_POPRD: begin
                bus.MemReq     = 1'b1;
                bus.MemAddrSrc = MA_SP;
                bus.MDRWrite   = bus.MemReady;
            end
            S_POPINC: begin
                bus.SrcA    = SRCA_SP;
                bus.SrcB    = SRCB_INC;
                bus.ALUOP   = OP_ADD;
                bus.SPWrite = 1'b1;
            end
            S_POPWB: begin
                bus.SrcB     = SRCB_MDR;
                bus.ALUOP    = OP_PASSB;
                bus.ACCWrite = 1'b1;
            end
            S_HALT:  bus.Halted = 1'b1;
            S_ERROR: bus.Halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.IllegalOp = illegal_q;
    assign bus.BusError  = bus_err_q;
    assign bus.State     = state_q;

endmodule

// File: tb/tb_acc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_acc_ctrl_fsm
// Vector table of whole instructions from reset, hand-written corner cases,
// then a randomized run against an instruction-level reference model.
// ---------------------------------------------------------------------------
module tb_acc_ctrl_fsm;

    localparam int MAXW = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    acc_ctrl_fsm_if bus_if ();

    acc_ctrl_fsm #(.MAX_WAIT(MAXW), .PC_INC(2)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus_if.master)
    );

    typedef struct packed {
        logic [2:0] srca;
        logic [3:0] srcb;
        logic [2:0] aluop;
        logic [1:0] mas;
        logic req, wr, irw, mdrw, pcw, accw, spw, halt;
    } ctrl_t;

    typedef struct {
        logic [3:0]  op;
        bit          az;
        logic [31:0] rdy;
        string       seq;
    } vec_t;

    ctrl_t act_c;
    assign act_c = {bus_if.SrcA, bus_if.SrcB, bus_if.ALUOP, bus_if.MemAddrSrc,
                    bus_if.MemReq, bus_if.MemWrite, bus_if.IRWrite, bus_if.MDRWrite,
                    bus_if.PCWrite, bus_if.ACCWrite, bus_if.SPWrite, bus_if.Halted};

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of the states still to visit for the current
    // instruction, the latched opcode, stall count and sticky flags.
    int         mq[$];
    logic [3:0] m_op;
    int         m_wait;
    bit         m_ill, m_bus;

    vec_t vt[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Expected outputs for a given state, written from the per-state table.
    function automatic ctrl_t exp_ctrl(input int st, input logic [3:0] op, input bit az, input bit rdy);
        ctrl_t c = '0;
        case (st)
            1:  begin c.req = 1; c.srcb = 4; c.irw = rdy; c.pcw = rdy; end
            3:  begin c.req = 1; c.mas = 1; c.mdrw = rdy; end
            4:  begin
                    c.srca = 1; c.accw = 1; c.srcb = (op == 4) ? 4'd1 : 4'd0;
                    c.aluop = (op == 1) ? 3'd1 : (op == 2) ? 3'd2 : (op == 3) ? 3'd3 :
                              (op == 5) ? 3'd4 : 3'd0;
                end
            5:  begin c.req = 1; c.wr = 1; c.mas = 1; end
            6:  begin c.srcb = 3; c.pcw = (op == 7) ? az : !az; end
            7:  begin c.srcb = 2; c.aluop = 4; c.pcw = 1; end
            8:  begin c.srca = 2; c.srcb = 4; c.aluop = 1; c.spw = 1; end
            9:  begin c.req = 1; c.wr = 1; c.mas = 2; end
            10: begin c.req = 1; c.mas = 2; c.mdrw = rdy; end
            11: begin c.srca = 2; c.srcb = 4; c.spw = 1; end
            12: begin c.srcb = 0; c.aluop = 4; c.accw = 1; end
            13, 14: c.halt = 1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic void model_reset();
        mq = {0, 1, 2};
        m_op = 4'h0;
        m_wait = 0;
        m_ill = 0;
        m_bus = 0;
    endfunction

    function automatic void model_step(input bit rdy, input logic [3:0] op);
        int  st = mq[0];
        bit  is_mem = (st == 1) || (st == 3) || (st == 5) || (st == 9) || (st == 10);
        if (st == 13 || st == 14) return;
        if (is_mem && !rdy) begin
            m_wait++;
            if (m_wait == MAXW) begin
                mq = {14};
                m_bus = 1;
                m_wait = 0;
            end
            return;
        end
        m_wait = 0;
        void'(mq.pop_front());
        if (st == 2) begin
            m_op = op;
            case (op)
                4'h0, 4'h1, 4'h2, 4'h3, 4'h5: mq = {3, 4};
                4'h4: mq = {4};
                4'h6: mq = {5};
                4'h7, 4'h8: mq = {6};
                4'h9: mq = {7};
                4'hA: mq = {8, 9};
                4'hB: mq = {10, 11, 12};
                4'hF: mq = {13};
                default: begin mq = {14}; m_ill = 1; end
            endcase
        end
        if (mq.size() == 0) mq = {1, 2};
    endfunction

    function automatic int hexval(input byte c);
        return (c >= "A") ? (c - "A" + 10) : (c - "0");
    endfunction

    function automatic void add_vec(input logic [3:0] op, input bit az, input logic [31:0] rdy, input string seq);
        vec_t v;
        v.op = op; v.az = az; v.rdy = rdy; v.seq = seq;
        vt.push_back(v);
    endfunction

    // Holds reset across one edge, checks the reset outputs, releases it
    // away from the clock edge. Leaves the DUT in INIT.
    task automatic do_reset();
        rst = 1'b1;
        bus_if.MemReady = 1'b0;
        #1;
        check("reset_state", {28'd0, bus_if.State}, 32'd0);
        check("reset_ctrl", {12'd0, act_c}, 32'd0);
        check("reset_flags", {30'd0, bus_if.IllegalOp, bus_if.BusError}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: drive inputs, compare everything with the model, advance.
    task automatic cycle(input logic [3:0] op, input bit az, input bit rdy, input string tag);
        ctrl_t ec;
        bus_if.Opcode = op;
        bus_if.AccZero = az;
        bus_if.MemReady = rdy;
        #1;
        ec = exp_ctrl(mq[0], m_op, az, rdy);
        check({tag, "_state"}, {28'd0, bus_if.State}, 32'(mq[0]));
        check({tag, "_ctrl"}, {12'd0, act_c}, {12'd0, ec});
        check({tag, "_flags"}, {30'd0, bus_if.IllegalOp, bus_if.BusError}, {30'd0, m_ill, m_bus});
        model_step(rdy, op);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.Opcode = 4'h0;
        bus_if.AccZero = 1'b0;
        bus_if.MemReady = 1'b0;

        // Each vector starts from reset; seq gives one state per cycle.
        add_vec(4'h4, 0, 32'hFFFFFFFF, "01241");
        add_vec(4'h1, 0, 32'hFFFFFFC7, "012333341");
        add_vec(4'h0, 0, 32'hFFFFFFFF, "012341");
        add_vec(4'h2, 1, 32'hFFFFFFFF, "012341");
        add_vec(4'h3, 0, 32'hFFFFFFFF, "012341");
        add_vec(4'h5, 0, 32'hFFFFFFFF, "012341");
        add_vec(4'h6, 0, 32'hFFFFFFFF, "01251");
        add_vec(4'h7, 1, 32'hFFFFFFFF, "01261");
        add_vec(4'h7, 0, 32'hFFFFFFFF, "01261");
        add_vec(4'h8, 1, 32'hFFFFFFFF, "01261");
        add_vec(4'h8, 0, 32'hFFFFFFFF, "01261");
        add_vec(4'h9, 0, 32'hFFFFFFFF, "01271");
        add_vec(4'hA, 0, 32'hFFFFFFFF, "012891");
        add_vec(4'hB, 0, 32'hFFFFFFFF, "012ABC1");
        add_vec(4'hF, 0, 32'hFFFFFFFF, "012DDD");
        add_vec(4'hD, 0, 32'hFFFFFFFF, "012EEE");
        add_vec(4'hC, 0, 32'hFFFFFFFF, "012EE");
        add_vec(4'hE, 0, 32'hFFFFFFFF, "012EE");
        add_vec(4'h0, 0, 32'h00000000, {"0", "11111", "11111", "11111", "EE"});
        add_vec(4'h0, 0, 32'hFFFF8001, {"0", "11111", "11111", "11111", "2"});
        add_vec(4'h1, 0, 32'h00000007, {"012", "33333", "33333", "33333", "E"});

        foreach (vt[k]) begin
            do_reset();
            for (int i = 0; i < vt[k].seq.len(); i++) begin
                bus_if.Opcode = vt[k].op;
                bus_if.AccZero = vt[k].az;
                bus_if.MemReady = vt[k].rdy[i];
                #1;
                check($sformatf("vec%0d_cyc%0d_seq", k, i), {28'd0, bus_if.State},
                      32'(hexval(vt[k].seq[i])));
                #1;
                cycle(vt[k].op, vt[k].az, vt[k].rdy[i], $sformatf("vec%0d_cyc%0d", k, i));
            end
            $display("vector %0d op=%h az=%0d cycles=%0d checks=%0d errors=%0d",
                     k, vt[k].op, vt[k].az, vt[k].seq.len(), checks, errors);
        end

        // Opcode changes after DECODE must not affect the ALU selects.
        do_reset();
        cycle(4'h1, 0, 1, "latch_init");
        cycle(4'h1, 0, 1, "latch_fetch");
        cycle(4'h1, 0, 1, "latch_decode");
        cycle(4'h5, 0, 1, "latch_memrd");
        bus_if.Opcode = 4'h4;
        #1;
        check("latch_alu_aluop", {29'd0, bus_if.ALUOP}, 32'd1);
        check("latch_alu_srcb", {28'd0, bus_if.SrcB}, 32'd0);
        $display("sequence opcode_latch checks=%0d errors=%0d", checks, errors);

        // Reset in the middle of a store drops MemReq without a clock edge.
        do_reset();
        cycle(4'h6, 0, 1, "rstmid_init");
        cycle(4'h6, 0, 1, "rstmid_fetch");
        cycle(4'h6, 0, 1, "rstmid_decode");
        cycle(4'h6, 0, 0, "rstmid_memwr");
        check("rstmid_req_before", {31'd0, bus_if.MemReq}, 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid_req_after", {31'd0, bus_if.MemReq}, 32'd0);
        check("rstmid_state_after", {28'd0, bus_if.State}, 32'd0);
        $display("sequence reset_mid_store checks=%0d errors=%0d", checks, errors);

        // Randomized run: opcode may change every cycle, MemReady is random
        // with occasional long stalls, and reset strikes now and then.
        do_reset();
        begin
            int stall = 0;
            int term = 0;
            for (int n = 0; n < 4000; n++) begin
                logic [3:0] op = 4'($urandom_range(0, 15));
                bit az = 1'($urandom_range(0, 1));
                bit rdy;
                if (stall == 0 && $urandom_range(0, 60) == 0) stall = $urandom_range(10, 18);
                if (stall > 0) begin
                    rdy = 1'b0;
                    stall--;
                end else begin
                    rdy = ($urandom_range(0, 9) < 7);
                end
                cycle(op, az, rdy, $sformatf("rand%0d", n));
                term = (mq[0] == 13 || mq[0] == 14) ? term + 1 : 0;
                if (term > 3 || $urandom_range(0, 300) == 0) begin
                    do_reset();
                    term = 0;
                    stall = 0;
                end
            end
        end
        $display("random run checks=%0d errors=%0d", checks, errors);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_ctrl_fsm.md
Name: acc_ctrl_fsm

Overview:
- Multicycle control unit for the 16-bit accumulator datapath.
- Sequences fetch, decode, execute and writeback by driving the ALU source selects (SrcA/SrcB), ALUOP, the memory handshake and all register write strobes.
- Sits beside the ALU subsystem and takes the opcode from the instruction register.
- Instruction format: opcode [15:12], immediate [11:0]. The datapath forms SE/ZE/SL1 from the immediate.

Parameters:
MAX_WAIT, 15, memory wait cycles tolerated before bus error (1..255)
PC_INC, 2, informational byte increment; the datapath applies it when SrcB=4

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-high reset
Opcode  input  4  IR[15:12]
AccZero  input  1  1 when ACC==0
MemReady  input  1  memory access complete this cycle
SrcA  output  3  0=PC, 1=ACC, 2=SP
SrcB  output  4  0=MDR, 1=SE, 2=ZE, 3=SL1, 4=const PC_INC, 5=const 0
ALUOP  output  3  0=ADD, 1=SUB, 2=AND, 3=OR, 4=PASSB
MemAddrSrc  output  2  0=PC, 1=ZE, 2=SP
MemReq  output  1  memory request; held until MemReady
MemWrite  output  1  1=write (data=ACC), 0=read
IRWrite, MDRWrite, PCWrite, ACCWrite, SPWrite  output  1 each  register load strobes
Halted  output  1  core stopped
IllegalOp  output  1  sticky: illegal opcode seen
BusError  output  1  sticky: memory timeout
State  output  4  current state (debug)

Behaviour:
- Registered state. Outputs are a combinational Moore decode of state. Memory-state strobes are additionally gated by MemReady.
- Output defaults in every state: all strobes 0, MemReq 0, SrcA/SrcB/ALUOP/MemAddrSrc 0.
- Reset: state=INIT(0), wait counter=0, IllegalOp=BusError=0. All outputs are at their defaults during and immediately after reset. RST mid-access drops MemReq asynchronously.
- State encoding: INIT0 FETCH1 DECODE2 MEMRD3 ALU4 MEMWR5 BRANCH6 JUMP7 SPDEC8 PUSHWR9 POPRD10 POPINC11 POPWB12 HALT13 ERROR14.
- INIT -> FETCH unconditionally.
- FETCH: MemReq=1, MemAddrSrc=PC. When MemReady: IRWrite=1, PCWrite=1 with SrcA=PC, SrcB=4, ADD; next state DECODE. Otherwise stay.
- DECODE: one cycle, no strobes. Dispatch on Opcode:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 5 LOAD -> MEMRD
  - 4 ADDI -> ALU
  - 6 STORE -> MEMWR
  - 7 BEQ, 8 BNE -> BRANCH
  - 9 JUMP -> JUMP
  - A PUSH -> SPDEC
  - B POP -> POPRD
  - F HALT -> HALT
  - C/D/E -> ERROR with IllegalOp set
- Opcode is latched at DECODE. A change on the Opcode input after DECODE has no effect.
- MEMRD: MemReq=1, MemAddrSrc=ZE. MDRWrite=MemReady. On MemReady -> ALU.
- ALU: SrcA=ACC, ACCWrite=1, then -> FETCH. SrcB=MDR, except ADDI uses SE. ALUOP = ADD/SUB/AND/OR by latched opcode; LOAD uses PASSB.
- MEMWR: MemReq=1, MemWrite=1, MemAddrSrc=ZE. On MemReady -> FETCH.
- BRANCH: SrcA=PC, SrcB=SL1, ADD. PCWrite = AccZero for BEQ, !AccZero for BNE. -> FETCH.
- JUMP: SrcB=ZE, PASSB, PCWrite=1. -> FETCH.
- SPDEC: SrcA=SP, SrcB=4, SUB, SPWrite. -> PUSHWR.
- PUSHWR: MemReq, MemWrite, MemAddrSrc=SP. On MemReady -> FETCH.
- POPRD: MemReq, MemAddrSrc=SP, MDRWrite=MemReady. On MemReady -> POPINC.
- POPINC: SrcA=SP, SrcB=4, ADD, SPWrite. -> POPWB.
- POPWB: SrcB=MDR, PASSB, ACCWrite. -> FETCH.
- Wait counter (8-bit): cleared on entry to any memory state; increments each cycle MemReq=1 and MemReady=0. Reaching MAX_WAIT -> ERROR with BusError set. MemReady in the same cycle the count hits MAX_WAIT wins: normal transition, no error.
- HALT: Halted=1. ERROR: Halted=1. Both are terminal until RST.
- MemReady outside a memory state is ignored.

Test Plan:
1. RST pulse, then MemReady=1 continuously, Opcode=4 -> sequence 0,1,2,4,1; IRWrite and PCWrite high in FETCH; ACCWrite high in ALU with SrcB=1, ALUOP=0.
2. Opcode=1 (SUB) with MemReady delayed 3 cycles in MEMRD -> MemReq held 4 cycles, MDRWrite exactly 1 cycle, ALU state shows SrcA=1, SrcB=0, ALUOP=1.
3. Opcode=7 with AccZero=1, then with AccZero=0 -> PCWrite=1 in BRANCH (SrcB=3), then PCWrite=0 in BRANCH; Opcode=8 gives the inverse.
4. PUSH then POP -> states 8,9,1 then 10,11,12,1; SPWrite with ALUOP=1 then ALUOP=0; MemWrite only in state 9.
5. MemReady held 0 with MAX_WAIT=15 in FETCH -> ERROR after 15 cycles, BusError=Halted=1; MemReady on cycle 15 instead -> DECODE, no error.
6. Opcode=0xD -> ERROR, IllegalOp=1. Opcode=0xF -> HALT, Halted=1. RST asserted mid-MEMWR -> MemReq=0 immediately, state=0.
